// File: rtl/mtimer_pkg.sv
// Shared definitions for the AHB-Lite machine timer: transfer encodings, register
// map, CTRL fields and the lane/parity/checksum helpers used by the slave port.
package mtimer_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RSP_OKAY = 2'd0,
        RSP_ERR1 = 2'd1,
        RSP_ERR2 = 2'd2
    } rsp_state_e;

    // Word indices (offset >> 2); MTIMECMP[h] occupies words 4+2h and 5+2h.
    localparam int WORD_MTIME_LO = 0;
    localparam int WORD_MTIME_HI = 1;
    localparam int WORD_CTRL     = 2;
    localparam int WORD_RSVD     = 3;
    localparam int WORD_CMP_BASE = 4;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIV_LSB = 8;

    function automatic logic [3:0] byte_enables(input logic [1:0] addr, input logic [1:0] size);
        case (size)
            2'd0:    return 4'b0001 << addr;
            2'd1:    return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

    // Hamming-style SEC code over 32 bits plus an overall parity bit.
    function automatic logic [6:0] edac_checksum(input logic [31:0] data);
        logic [6:0] c;
        int         pos;
        c   = '0;
        pos = 2;
        for (int j = 0; j < 32; j++) begin
            pos++;
            if ((pos & (pos - 1)) == 0) pos++;
            for (int i = 0; i < 6; i++) begin
                if (pos[i]) c[i] = c[i] ^ data[j];
            end
        end
        c[6] = ^{data, c[5:0]};
        return c;
    endfunction

    function automatic logic [5:0] ahb_parity(input logic [31:0] haddr,
                                              input logic [1:0]  htrans,
                                              input logic        hwrite,
                                              input logic [2:0]  hsize,
                                              input logic [2:0]  hburst,
                                              input logic [3:0]  hprot,
                                              input logic        hmastlock);
        logic [5:0] p;
        p[0] = ^haddr[7:0];
        p[1] = ^haddr[15:8];
        p[2] = ^haddr[23:16];
        p[3] = ^haddr[31:24];
        p[4] = ^{htrans, hwrite, hsize};
        p[5] = ^{hburst, hprot, hmastlock};
        return p;
    endfunction

endpackage

// File: rtl/mtimer_cmp.sv
// One 64-bit MTIMECMP register with byte-lane writes and a registered
// MTIME >= MTIMECMP compare driving that hart's timer interrupt.
module mtimer_cmp
    import mtimer_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic [3:0]  be_lo,
    input  logic [3:0]  be_hi,
    input  logic [31:0] wdata,
    input  logic [63:0] mtime,
    output logic [63:0] cmp,
    output logic        mtip
);

    logic [63:0] cmp_reg;
    logic        mtip_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            cmp_reg  <= '1;
            mtip_reg <= 1'b0;
        end else begin
            if (|be_lo) cmp_reg[31:0]  <= merge_bytes(cmp_reg[31:0], wdata, be_lo);
            if (|be_hi) cmp_reg[63:32] <= merge_bytes(cmp_reg[63:32], wdata, be_hi);
            mtip_reg <= (mtime >= cmp_reg);
        end
    end

    assign cmp  = cmp_reg;
    assign mtip = mtip_reg;

endmodule

// File: rtl/ahb_mtimer_multi.sv
// ACLINT-style machine timer (shared prescaled MTIME, N_HARTS MTIMECMP) behind an
// AHB-Lite slave. Define AHB_MTIMER_IFP_EN to add address parity and data checksums.
module ahb_mtimer_multi
    import mtimer_pkg::*;
#(
    parameter int N_HARTS   = 1,
    parameter int PRESC_W   = 8,
    parameter int PRESC_RST = 0
) (
    input  logic               s_clk_i,
    input  logic               s_reset_i,
    input  logic [31:0]        s_haddr_i,
    input  logic [31:0]        s_hwdata_i,
    input  logic [2:0]         s_hburst_i,
    input  logic               s_hmastlock_i,
    input  logic [3:0]         s_hprot_i,
    input  logic [2:0]         s_hsize_i,
    input  logic [1:0]         s_htrans_i,
    input  logic               s_hwrite_i,
    input  logic               s_hsel_i,
`ifdef AHB_MTIMER_IFP_EN
    input  logic [5:0]         s_hparity_i,
    input  logic [6:0]         s_hwchecksum_i,
    output logic [6:0]         s_hrchecksum_o,
`endif
    output logic [31:0]        s_hrdata_o,
    output logic               s_hready_o,
    output logic               s_hresp_o,
    output logic [N_HARTS-1:0] s_mtip_o
);

    localparam int N_BYTES = 16 + 8 * N_HARTS;
    localparam int AW      = $clog2(N_BYTES);
    localparam int WW      = AW - 2;
    localparam logic [AW:0] ADDR_LIMIT = (AW + 1)'(N_BYTES);

    rsp_state_e           rsp_state_reg;
    logic                 hready_reg, hresp_reg;
    logic                 dp_valid_reg, dp_write_reg;
    logic [AW-1:0]        dp_addr_reg;
    logic [1:0]           dp_size_reg;
    logic [63:0]          mtime_reg, mtime_next, mtime_inc;
    logic                 en_reg;
    logic [PRESC_W-1:0]   div_reg, presc_cnt_reg;
    logic [63:0]          cmp_val [N_HARTS];
    logic [31:0]          rdata_next, ctrl_word, ctrl_new;
    logic                 unused_bits;

    // ---------------- address phase ----------------
    logic          addr_sel, addr_err, par_err;
    logic [AW-1:0] offset;

    assign offset   = s_haddr_i[AW-1:0];
    assign addr_sel = s_hsel_i && hready_reg &&
                      (s_htrans_i == HTRANS_NONSEQ || s_htrans_i == HTRANS_SEQ);
`ifdef AHB_MTIMER_IFP_EN
    assign par_err  = ahb_parity(s_haddr_i, s_htrans_i, s_hwrite_i, s_hsize_i,
                                 s_hburst_i, s_hprot_i, s_hmastlock_i) != s_hparity_i;
`else
    assign par_err  = 1'b0;
`endif
    assign addr_err = ({1'b0, offset} >= ADDR_LIMIT) || (s_hsize_i > 3'd2) ||
                      (s_hsize_i == 3'd1 && s_haddr_i[0]) ||
                      (s_hsize_i == 3'd2 && |s_haddr_i[1:0]) || par_err;

    assign unused_bits = ^{s_hburst_i, s_hmastlock_i, s_hprot_i, s_haddr_i[31:AW]};

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            rsp_state_reg <= RSP_OKAY;
            hready_reg    <= 1'b1;
            hresp_reg     <= 1'b0;
            dp_valid_reg  <= 1'b0;
            dp_write_reg  <= 1'b0;
            dp_addr_reg   <= '0;
            dp_size_reg   <= '0;
        end else begin
            dp_valid_reg <= 1'b0;
            if (rsp_state_reg == RSP_ERR1) begin
                rsp_state_reg <= RSP_ERR2;
                hready_reg    <= 1'b1;
                hresp_reg     <= 1'b1;
            end else if (addr_sel && addr_err) begin
                rsp_state_reg <= RSP_ERR1;
                hready_reg    <= 1'b0;
                hresp_reg     <= 1'b1;
            end else begin
                rsp_state_reg <= RSP_OKAY;
                hready_reg    <= 1'b1;
                hresp_reg     <= 1'b0;
                if (addr_sel) begin
                    dp_valid_reg <= 1'b1;
                    dp_write_reg <= s_hwrite_i;
                    dp_addr_reg  <= offset;
                    dp_size_reg  <= s_hsize_i[1:0];
                end
            end
        end
    end

    // ---------------- data phase ----------------
    logic [WW-1:0] dp_word;
    logic [3:0]    wr_be;
    logic          wr_en, wchk_ok, wr_mtime_lo, wr_mtime_hi, wr_ctrl;

    assign dp_word = dp_addr_reg[AW-1:2];
    assign wr_be   = byte_enables(dp_addr_reg[1:0], dp_size_reg);
`ifdef AHB_MTIMER_IFP_EN
    assign wchk_ok = edac_checksum(s_hwdata_i) == s_hwchecksum_i;
`else
    assign wchk_ok = 1'b1;
`endif
    assign wr_en       = dp_valid_reg && dp_write_reg && wchk_ok;
    assign wr_mtime_lo = wr_en && dp_word == WW'(WORD_MTIME_LO);
    assign wr_mtime_hi = wr_en && dp_word == WW'(WORD_MTIME_HI);
    assign wr_ctrl     = wr_en && dp_word == WW'(WORD_CTRL);

    // ---------------- prescaler and MTIME ----------------
    logic tick;
    assign tick      = en_reg && (presc_cnt_reg == div_reg);
    assign ctrl_word = {{(24 - PRESC_W){1'b0}}, div_reg, 7'd0, en_reg};
    assign ctrl_new  = merge_bytes(ctrl_word, s_hwdata_i, wr_be);

    // The increment is applied first so a carry reaches an unwritten word.
    always_comb begin
        mtime_inc  = mtime_reg + {63'd0, tick};
        mtime_next = mtime_inc;
        if (wr_mtime_lo) mtime_next[31:0]  = merge_bytes(mtime_inc[31:0], s_hwdata_i, wr_be);
        if (wr_mtime_hi) mtime_next[63:32] = merge_bytes(mtime_inc[63:32], s_hwdata_i, wr_be);
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            mtime_reg     <= '0;
            en_reg        <= 1'b1;
            div_reg       <= PRESC_W'(PRESC_RST);
            presc_cnt_reg <= '0;
        end else begin
            mtime_reg <= mtime_next;
            if (wr_ctrl) begin
                en_reg        <= ctrl_new[CTRL_EN_BIT];
                div_reg       <= ctrl_new[CTRL_DIV_LSB +: PRESC_W];
                presc_cnt_reg <= '0;
            end else if (tick) begin
                presc_cnt_reg <= '0;
            end else if (en_reg) begin
                presc_cnt_reg <= presc_cnt_reg + PRESC_W'(1);
            end
        end
    end

    // ---------------- per-hart compare ----------------
    for (genvar gi = 0; gi < N_HARTS; gi++) begin : g_cmp
        logic [3:0] be_lo, be_hi;
        assign be_lo = (wr_en && dp_word == WW'(WORD_CMP_BASE + 2 * gi))     ? wr_be : 4'b0;
        assign be_hi = (wr_en && dp_word == WW'(WORD_CMP_BASE + 2 * gi + 1)) ? wr_be : 4'b0;

        mtimer_cmp u_cmp (
            .clk   (s_clk_i),
            .srst  (s_reset_i),
            .be_lo (be_lo),
            .be_hi (be_hi),
            .wdata (s_hwdata_i),
            .mtime (mtime_reg),
            .cmp   (cmp_val[gi]),
            .mtip  (s_mtip_o[gi])
        );
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata_next = '0;
        if (dp_valid_reg && !dp_write_reg) begin
            if (dp_word == WW'(WORD_MTIME_LO)) rdata_next = mtime_reg[31:0];
            if (dp_word == WW'(WORD_MTIME_HI)) rdata_next = mtime_reg[63:32];
            if (dp_word == WW'(WORD_CTRL))     rdata_next = ctrl_word;
            for (int h = 0; h < N_HARTS; h++) begin
                if (dp_word == WW'(WORD_CMP_BASE + 2 * h))     rdata_next = cmp_val[h][31:0];
                if (dp_word == WW'(WORD_CMP_BASE + 2 * h + 1)) rdata_next = cmp_val[h][63:32];
            end
        end
    end

    assign s_hrdata_o = rdata_next;
    assign s_hready_o = hready_reg;
    assign s_hresp_o  = hresp_reg;
`ifdef AHB_MTIMER_IFP_EN
    assign s_hrchecksum_o = edac_checksum(rdata_next);
`endif

endmodule

// File: tb/tb_ahb_mtimer_multi.sv
// Directed bench for ahb_mtimer_multi with four harts: register vector table plus
// hand-timed sequences for prescaling, interrupt latency, wrap, errors and reset.
module tb_ahb_mtimer_multi;

    localparam int N = 4;

    logic        clk;
    logic        srst;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hburst, hsize;
    logic        hmastlock, hwrite, hsel, hready, hresp;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [N-1:0] mtip;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_mtimer_multi #(.N_HARTS(N), .PRESC_W(8), .PRESC_RST(0)) dut (
        .s_clk_i       (clk),
        .s_reset_i     (srst),
        .s_haddr_i     (haddr),
        .s_hwdata_i    (hwdata),
        .s_hburst_i    (hburst),
        .s_hmastlock_i (hmastlock),
        .s_hprot_i     (hprot),
        .s_hsize_i     (hsize),
        .s_htrans_i    (htrans),
        .s_hwrite_i    (hwrite),
        .s_hsel_i      (hsel),
        .s_hrdata_o    (hrdata),
        .s_hready_o    (hready),
        .s_hresp_o     (hresp),
        .s_mtip_o      (mtip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that ends
    // the transfer. resp: 0 OKAY, 1 well-formed two-cycle ERROR, 2 malformed.
    task automatic ahb(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rdata, output int resp);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = wdata;
        @(negedge clk);
        rdata = hrdata;
        if (hready === 1'b1 && hresp === 1'b0) begin
            resp = 0;
        end else if (hready === 1'b0 && hresp === 1'b1) begin
            @(negedge clk);
            resp = (hready === 1'b1 && hresp === 1'b1) ? 1 : 2;
        end else begin
            resp = 2;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          exp_resp;
    } vec_t;

    vec_t vt[28];

    initial begin
        logic [31:0] rd, m0, m1;
        int          resp, rise;
        logic [N-1:0] rise_val;

        vt[0]  = '{1, 32'h08, 3'd2, 32'h0000_0000, 32'h0,          0}; // EN=0: freeze MTIME
        vt[1]  = '{0, 32'h08, 3'd2, 32'h0,         32'h0000_0000,  0};
        vt[2]  = '{1, 32'h00, 3'd2, 32'h1234_5678, 32'h0,          0};
        vt[3]  = '{0, 32'h00, 3'd2, 32'h0,         32'h1234_5678,  0};
        vt[4]  = '{1, 32'h04, 3'd2, 32'hCAFE_F00D, 32'h0,          0};
        vt[5]  = '{0, 32'h04, 3'd2, 32'h0,         32'hCAFE_F00D,  0};
        vt[6]  = '{1, 32'h0C, 3'd2, 32'hFFFF_FFFF, 32'h0,          0};
        vt[7]  = '{0, 32'h0C, 3'd2, 32'h0,         32'h0000_0000,  0};
        vt[8]  = '{1, 32'h19, 3'd0, 32'h0000_AB00, 32'h0,          0};
        vt[9]  = '{0, 32'h18, 3'd2, 32'h0,         32'hFFFF_ABFF,  0};
        vt[10] = '{1, 32'h1A, 3'd1, 32'h1234_0000, 32'h0,          0};
        vt[11] = '{0, 32'h18, 3'd2, 32'h0,         32'h1234_ABFF,  0};
        vt[12] = '{1, 32'h08, 3'd2, 32'hFFFF_FF00, 32'h0,          0};
        vt[13] = '{0, 32'h08, 3'd2, 32'h0,         32'h0000_FF00,  0};
        vt[14] = '{0, 32'h30, 3'd2, 32'h0,         32'h0,          1}; // past last MTIMECMP
        vt[15] = '{0, 32'h02, 3'd2, 32'h0,         32'h0,          1}; // misaligned word
        vt[16] = '{1, 32'h10, 3'd3, 32'h0000_DEAD, 32'h0,          1}; // hsize=3
        vt[17] = '{0, 32'h10, 3'd2, 32'h0,         32'hFFFF_FFFF,  0};
        vt[18] = '{1, 32'h01, 3'd1, 32'hFFFF_FFFF, 32'h0,          1}; // misaligned halfword
        vt[19] = '{0, 32'h00, 3'd2, 32'h0,         32'h1234_5678,  0};
        vt[20] = '{1, 32'h16, 3'd1, 32'hBEEF_0000, 32'h0,          0};
        vt[21] = '{0, 32'h14, 3'd2, 32'h0,         32'hBEEF_FFFF,  0};
        vt[22] = '{0, 32'h2C, 3'd2, 32'h0,         32'hFFFF_FFFF,  0}; // last valid word
        vt[23] = '{0, 32'h1B, 3'd0, 32'h0,         32'h1234_ABFF,  0};
        vt[24] = '{0, 32'h2E, 3'd1, 32'h0,         32'hFFFF_FFFF,  0};
        vt[25] = '{1, 32'h04, 3'd2, 32'h0000_0000, 32'h0,          0};
        vt[26] = '{1, 32'h00, 3'd2, 32'h0000_0000, 32'h0,          0};
        vt[27] = '{1, 32'h08, 3'd2, 32'h0000_0001, 32'h0,          0}; // EN=1, DIV=0

        srst = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hwdata = '0;
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hmastlock = 1'b0; hprot = 4'd0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;

        @(negedge clk);
        check("reset_hready", hready, 1);
        check("reset_hresp", hresp, 0);
        check("reset_hrdata", hrdata, 0);
        check("reset_mtip", mtip, 0);

        // Free-running count after reset: read lands 100 cycles after release.
        repeat (99) @(posedge clk);
        #1;
        ahb(0, 32'h00, 3'd2, 32'h0, rd, resp);
        check_range("idle100_mtime", rd, 98, 102);
        check("idle100_mtip", mtip, 0);

        for (int i = 0; i < 28; i++) begin
            ahb(vt[i].wr, vt[i].addr, vt[i].size, vt[i].wdata, rd, resp);
            check($sformatf("vec%0d_resp", i), resp, vt[i].exp_resp);
            if (!vt[i].wr && vt[i].exp_resp == 0)
                check($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
        end

        // Address phase presented during the first error cycle must be ignored.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b0; hsize = 3'd2;
        @(posedge clk); #1;
        haddr = 32'h10; hwrite = 1'b1;
        @(negedge clk);
        check("err1_hready", hready, 0);
        check("err1_hresp", hresp, 1);
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1111_1111;
        @(negedge clk);
        check("err2_hready", hready, 1);
        check("err2_hresp", hresp, 1);
        @(posedge clk); #1;
        ahb(0, 32'h10, 3'd2, 32'h0, rd, resp);
        check("err_ignored_cmp0", rd, 32'hFFFF_FFFF);

        // DIV=3: one tick every 4 cycles; reads are exactly 40 cycles apart.
        ahb(1, 32'h08, 3'd2, 32'h0000_0301, rd, resp);
        ahb(0, 32'h00, 3'd2, 32'h0, m0, resp);
        repeat (38) @(posedge clk);
        #1;
        ahb(0, 32'h00, 3'd2, 32'h0, m1, resp);
        check_range("div3_delta", longint'(m1) - longint'(m0), 9, 11);
        ahb(1, 32'h08, 3'd2, 32'h0000_0001, rd, resp);

        // MTIMECMP[2]=0x50 then MTIME=0x40: interrupt 17 cycles after the commit.
        ahb(1, 32'h00, 3'd2, 32'h0, rd, resp);
        ahb(1, 32'h20, 3'd2, 32'h0000_0050, rd, resp);
        ahb(1, 32'h24, 3'd2, 32'h0, rd, resp);
        ahb(1, 32'h00, 3'd2, 32'h0000_0040, rd, resp);
        rise = 0;
        rise_val = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mtip !== '0) begin
                rise = k;
                rise_val = mtip;
                break;
            end
        end
        check("mtip_rise_window", rise, 18);
        check("mtip_rise_value", rise_val, 4'b0100);

        // Wrap: all-ones MTIME sets every hart, rolling to 0 clears them.
        @(posedge clk); #1;
        ahb(1, 32'h04, 3'd2, 32'hFFFF_FFFF, rd, resp);
        ahb(1, 32'h00, 3'd2, 32'hFFFF_FFFF, rd, resp);
        @(negedge clk);
        check("wrap_mtip_pre", mtip, 4'b0101);
        @(negedge clk);
        check("wrap_mtip_allones", mtip, 4'b1111);
        @(negedge clk);
        check("wrap_mtip_after", mtip, 4'b0000);
        @(posedge clk); #1;
        ahb(0, 32'h00, 3'd2, 32'h0, rd, resp);
        check("wrap_mtime_lo", rd, 32'h0000_0003);
        ahb(0, 32'h04, 3'd2, 32'h0, rd, resp);
        check("wrap_mtime_hi", rd, 32'h0000_0000);

        // Reset during a write data phase abandons the write.
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h14; hwrite = 1'b1; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h2222_2222; srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk);
        check("midrst_hready", hready, 1);
        check("midrst_hresp", hresp, 0);
        check("midrst_mtip", mtip, 0);
        @(posedge clk); #1;
        ahb(0, 32'h14, 3'd2, 32'h0, rd, resp);
        check("midrst_cmp0_hi", rd, 32'hFFFF_FFFF);
        ahb(0, 32'h08, 3'd2, 32'h0, rd, resp);
        check("midrst_ctrl", rd, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_mtimer_multi.md
Name: ahb_mtimer_multi

Overview:
- Parametrised ACLINT-style machine timer with an AMBA 3 AHB-Lite slave port.
- One shared 64-bit MTIME counter with a programmable prescaler and enable, plus N_HARTS 64-bit MTIMECMP registers.
- Drives one registered timer-interrupt line per hart; instantiated on the peripheral AHB segment next to the memories.
- Adds error responses, prescaling and multi-hart compare.

Parameters:
- N_HARTS, 1, number of MTIMECMP registers and s_mtip_o bits (1..16).
- PRESC_W, 8, width of the prescaler divider field.
- PRESC_RST, 0, reset value of the divider; 0 means increment every enabled cycle.

Ports:
- s_clk_i  in  1  clock.
- s_reset_i  in  1  synchronous, active-high reset.
- s_haddr_i  in  32  AHB address.
- s_hwdata_i  in  32  AHB write data.
- s_hburst_i  in  3  AHB burst; ignored.
- s_hmastlock_i  in  1  AHB lock; ignored.
- s_hprot_i  in  4  AHB protection; ignored.
- s_hsize_i  in  3  AHB transfer size.
- s_htrans_i  in  2  AHB transfer type.
- s_hwrite_i  in  1  AHB write.
- s_hsel_i  in  1  slave select.
- s_hrdata_o  out  32  read data.
- s_hready_o  out  1  transfer done.
- s_hresp_o  out  1  1 = ERROR.
- s_mtip_o  out  N_HARTS  per-hart interrupt, bit h = MTIME >= MTIMECMP[h].

Behaviour:
- Reset is synchronous and active-high. Reset values: MTIME=0; MTIMECMP[h]=all ones; CTRL.EN=1; CTRL.DIV=PRESC_RST; prescaler count=0; s_mtip_o=0; s_hready_o=1; s_hresp_o=0; s_hrdata_o=0.
- Address map (offset = s_haddr_i[AW-1:0], AW=$clog2(16+8*N_HARTS)):
  - 0x00 MTIME[31:0]; 0x04 MTIME[63:32].
  - 0x08 CTRL: bit0 EN; bits[8+PRESC_W-1:8] DIV; other bits read 0.
  - 0x0C reserved: reads 0, writes ignored, OKAY.
  - 0x10+8h MTIMECMP[h][31:0]; 0x14+8h MTIMECMP[h][63:32].
- Address phase accepted when s_hsel_i & s_hready_o & htrans in {NONSEQ, SEQ}. IDLE/BUSY: OKAY, no action.
- Error condition, checked in the address phase:
  - offset >= 16+8*N_HARTS;
  - hsize > 2;
  - misaligned (halfword with addr[0]=1, word with addr[1:0]!=0).
- Error response is two cycles: first hready=0, hresp=1; second hready=1, hresp=1. No register changes. An address phase presented during the first cycle is ignored.
- OKAY transfers have zero wait states.
- Read: address/size latched in the address phase; s_hrdata_o is driven from the current register value in the data phase. Write-then-read to the same address returns the new value; no forwarding path is needed.
- Write: byte lanes are selected from the latched addr[1:0]/size (little-endian). The write commits at the end of the data phase.
- Tick = EN & (presc_cnt == DIV).
  - presc_cnt resets to 0 on tick, otherwise increments while EN.
  - Clearing EN holds presc_cnt. A write to CTRL clears presc_cnt.
- MTIME next = MTIME + tick (full 64-bit, wraps from all ones to 0).
  - Written bytes are then overwritten by hwdata: a bus write wins over the increment in the same cycle.
  - A carry into an unwritten word still propagates.
- s_mtip_o[h] is registered from (MTIME >= MTIMECMP[h]), unsigned 64-bit. It has 1-cycle latency after the register change.
- Reset asserted mid-transfer: the transfer is abandoned; the next cycle shows reset values.

Optional Feature:
- Macro: AHB_MTIMER_IFP_EN.
- When defined:
  - Adds ports s_hparity_i[5:0], s_hwchecksum_i[6:0] and s_hrchecksum_o[6:0].
  - Address/control parity uses the same 6-bit scheme as the other peripherals. A mismatch forces the two-cycle ERROR response and blocks the write.
  - s_hrchecksum_o = edac_checksum(s_hrdata_o).
  - A s_hwchecksum_i mismatch in the data phase blocks the write; the response stays OKAY.
- When undefined: the ports are absent and there is no checking.

Decomposition:
- Package mtimer_pkg: register offsets, CTRL field positions, HTRANS encodings.
- Sub-module mtimer_cmp: one MTIMECMP register with byte-lane write and registered compare, generated N_HARTS times.

Test Plan:
- Reset, DIV=0, EN=1, idle 100 cycles -> MTIME read = 100±2; s_mtip_o=0.
- Write CTRL DIV=3, wait 40 cycles -> MTIME advances by 10±1.
- N_HARTS=4: write MTIMECMP[2]=0x50, MTIME=0x40 -> s_mtip_o=4'b0100 exactly 17 cycles after the MTIME write; others stay 0.
- Write MTIME hi/lo = 0xFFFFFFFF_FFFFFFFF, DIV=0 -> reads 0x0 after wrap; all mtip drop.
- Read offset 0x10+8*N_HARTS; word access at 0x02; hsize=3 -> hready 0 then 1 with hresp=1; registers unchanged.
- Halfword write 0xBEEF to 0x16, then immediate word read 0x14 -> 0xBEEFxxxx, low half unchanged.
